// File: rtl/resp_sig_checker.sv
// resp_sig_checker: compacts the DUT's wide response `y` into a 32-bit MISR
// signature over a run of num_vec accepted vectors, then compares it with an
// expected signature and pulses done with pass/fail.
// Optional build macro: RESP_XCHK_EN adds a simulation-only sticky x_seen
// flag that forces pass low when an unknown response was accepted.
module resp_sig_checker #(
  parameter int          Y_W   = 385,
  parameter int          SIG_W = 32,
  parameter int          CNT_W = 8,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [Y_W-1:0]   y,
  input  logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             x_seen
);

  localparam int NW    = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W = NW * SIG_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;

  logic [PAD_W-1:0] y_pad;
  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] misr_next;
  logic             accept;
  logic             x_flag;

  // Zero-pad y to whole words and XOR them together; the top bit of y
  // therefore aliases onto bit 0 of the fold.
  always_comb begin
    y_pad          = '0;
    y_pad[Y_W-1:0] = y;
    fold           = '0;
    for (int k = 0; k < NW; k++) fold = fold ^ y_pad[k*SIG_W +: SIG_W];
  end

  assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
                   ^ fold;

  // A vector is taken only in RUN, before the count is reached.
  assign accept = (state_q == S_RUN) && (cnt_q != num_q) && y_valid;

`ifdef RESP_XCHK_EN
  logic x_seen_q, x_seen_d;

  // Sticky unknown-response flag, cleared by the next start.
  always_comb begin
    x_seen_d = x_seen_q;
    if (state_q == S_IDLE && start) x_seen_d = 1'b0;
    else if (accept && ((^y) === 1'bx)) x_seen_d = 1'b1;
  end

  // x_seen register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x_seen_q <= 1'b0;
    else        x_seen_q <= x_seen_d;
  end

  assign x_flag = x_seen_q;
`else
  assign x_flag = 1'b0;
`endif

  // Run FSM plus signature / counter next-state.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED[SIG_W-1:0];
          cnt_d   = '0;
          num_d   = num_vec;
          exp_d   = exp_sig;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == num_q) begin
          // sig is frozen this cycle, so the compare is final here.
          state_d = S_DONE;
          pass_d  = (sig_q == exp_q) && !x_flag;
        end else if (y_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= SEED[SIG_W-1:0];
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign pass    = pass_q;
  assign sig     = sig_q;
  assign vec_cnt = cnt_q;
  assign x_seen  = x_flag;

endmodule
